bus_irq_timer: RTL and testbench

- Memory-mapped responder on the 65C02 core's CPU bus: decodes AB/WE/DO, returns read data one cycle later, and drives the core's `irq` input.
- Contains a 16-bit down-counter timer and an 8-line edge-latched external interrupt controller.
- Sits beside RAM/ROM on the CPU bus; the system read mux selects `rdata` when `rvalid` is high.

---
 rtl/bus_irq_timer_pkg.sv | 28 ++
 rtl/bus_irq_timer_cnt.sv | 73 +++++++
 rtl/bus_irq_timer.sv | 134 +++++++++++++
 tb/tb_bus_irq_timer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bus_irq_timer_pkg.sv
// Shared register map, CTRL/STAT bit positions and CTRL layout for bus_irq_timer.
// Optional macro BUS_IRQ_TIMER_PRESCALE_EN makes the CTRL.ps field live.
package bus_irq_timer_pkg;

  localparam logic [2:0] OFF_CNT_LO = 3'd0;
  localparam logic [2:0] OFF_CNT_HI = 3'd1;
  localparam logic [2:0] OFF_RLD_LO = 3'd2;
  localparam logic [2:0] OFF_RLD_HI = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;
  localparam logic [2:0] OFF_STAT   = 3'd5;
  localparam logic [2:0] OFF_XMASK  = 3'd6;
  localparam logic [2:0] OFF_XPEND  = 3'd7;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int CTRL_TIE_BIT  = 2;
  localparam int STAT_TF_BIT   = 0;
  localparam int STAT_IRQ_BIT  = 7;

  typedef struct packed {
    logic [3:0] ps;
    logic       rsvd;
    logic       tie;
    logic       auto;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/bus_irq_timer_cnt.sv
// Timer core: tick generation (optional prescaler), 16-bit down-counter with reload, TF-set pulse.
// With BUS_IRQ_TIMER_PRESCALE_EN defined, ticks come from a prescaler bit selected by ps_i.
module bus_irq_timer_cnt
`ifdef BUS_IRQ_TIMER_PRESCALE_EN
#(
  parameter int PRESCALE_W = 8
)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en_i,
  input  logic        auto_i,
`ifdef BUS_IRQ_TIMER_PRESCALE_EN
  input  logic [3:0]  ps_i,
`endif
  input  logic [15:0] rld_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic [15:0] cnt_o,
  output logic        tf_set_o,
  output logic        en_clr_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        tick;

`ifdef BUS_IRQ_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] pre_q, pre_d, pre_inc;

  // A tick is the selected prescaler bit falling; out-of-range ps selects the MSB.
  always_comb begin
    pre_inc = pre_q + 1'b1;
    tick    = 1'b0;
    for (int i = 0; i < PRESCALE_W; i++) begin
      if ((int'(ps_i) == i) || ((i == PRESCALE_W - 1) && (int'(ps_i) >= PRESCALE_W))) begin
        tick = en_i & pre_q[i] & ~pre_inc[i];
      end
    end
    if (!en_i || load_i) pre_d = '0;
    else                 pre_d = pre_inc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pre_q <= '0;
    else          pre_q <= pre_d;
  end
`else
  assign tick = en_i;
`endif

  // A reload-high write beats the tick; TF still reports an expiry of the old count.
  always_comb begin
    cnt_d    = cnt_q;
    tf_set_o = tick && (cnt_q == 16'h0000);
    en_clr_o = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick) begin
      if (cnt_q != 16'h0000) cnt_d = cnt_q - 16'h0001;
      else if (auto_i)       cnt_d = rld_i;
      else                   en_clr_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 16'h0000;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_irq_timer.sv
// CPU-bus responder: 8-byte register window with timer and edge-latched external IRQs.
// Define BUS_IRQ_TIMER_PRESCALE_EN to enable the CTRL.ps prescaler.
module bus_irq_timer
  import bus_irq_timer_pkg::*;
#(
  parameter logic [15:0] BASE = 16'hFE00
`ifdef BUS_IRQ_TIMER_PRESCALE_EN
  , parameter int PRESCALE_W = 8
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  input  logic [7:0]  ext_irq,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        irq
);

  logic        hit, rd_hit, wr_hit;
  logic [2:0]  off;
  logic [15:0] cnt;
  logic        tf_set, en_clr, load;

  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] rld_q, rld_d;
  logic        tf_q, tf_d;
  logic [7:0]  xmask_q, xmask_d;
  logic [7:0]  xpend_q, xpend_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [7:0]  ext_irq_q;
  logic [7:0]  rdata_q, rdata_d, rd_val;
  logic        rvalid_q, irq_q, irq_d;
  logic [7:0]  xpend_clr;

  assign hit    = (AB[15:3] == BASE[15:3]);
  assign off    = AB[2:0];
  assign rd_hit = hit & ~WE;
  assign wr_hit = hit & WE;
  assign load   = wr_hit && (off == OFF_RLD_HI);

  bus_irq_timer_cnt
`ifdef BUS_IRQ_TIMER_PRESCALE_EN
    #(.PRESCALE_W(PRESCALE_W))
`endif
  u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .en_i       (ctrl_q.en),
    .auto_i     (ctrl_q.auto),
`ifdef BUS_IRQ_TIMER_PRESCALE_EN
    .ps_i       (ctrl_q.ps),
`endif
    .rld_i      (rld_q),
    .load_i     (load),
    .load_val_i ({DO, rld_q[7:0]}),
    .cnt_o      (cnt),
    .tf_set_o   (tf_set),
    .en_clr_o   (en_clr)
  );

  always_comb begin
    case (off)
      OFF_CNT_LO: rd_val = cnt[7:0];
      OFF_CNT_HI: rd_val = shadow_q;
      OFF_RLD_LO: rd_val = rld_q[7:0];
      OFF_RLD_HI: rd_val = rld_q[15:8];
      OFF_CTRL:   rd_val = ctrl_q;
      OFF_STAT:   rd_val = {irq_q, 6'b000000, tf_q};
      OFF_XMASK:  rd_val = xmask_q;
      default:    rd_val = xpend_q;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    rld_d    = rld_q;
    xmask_d  = xmask_q;
    shadow_d = shadow_q;
    if (wr_hit && (off == OFF_CTRL)) begin
      ctrl_d      = ctrl_t'(DO);
      ctrl_d.rsvd = 1'b0;
`ifndef BUS_IRQ_TIMER_PRESCALE_EN
      ctrl_d.ps   = 4'h0;
`endif
    end else if (en_clr) begin
      ctrl_d.en = 1'b0;
    end
    if (wr_hit && (off == OFF_RLD_LO)) rld_d[7:0]  = DO;
    if (load)                          rld_d[15:8] = DO;
    if (wr_hit && (off == OFF_XMASK))  xmask_d     = DO;
    if (rd_hit && (off == OFF_CNT_LO)) shadow_d    = cnt[15:8];
  end

  // Set events override same-cycle W1C clears.
  assign xpend_clr = (wr_hit && (off == OFF_XPEND)) ? DO : 8'h00;
  assign xpend_d   = (xpend_q & ~xpend_clr) | (ext_irq & ~ext_irq_q);
  assign tf_d      = (tf_q & ~(wr_hit && (off == OFF_STAT) && DO[STAT_TF_BIT])) | tf_set;
  assign irq_d     = (tf_q & ctrl_q.tie) | (|(xpend_q & xmask_q));
  assign rdata_d   = rd_hit ? rd_val : rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= '0;
      rld_q     <= 16'h0000;
      tf_q      <= 1'b0;
      xmask_q   <= 8'h00;
      xpend_q   <= 8'h00;
      shadow_q  <= 8'h00;
      ext_irq_q <= 8'h00;
      rdata_q   <= 8'h00;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      rld_q     <= rld_d;
      tf_q      <= tf_d;
      xmask_q   <= xmask_d;
      xpend_q   <= xpend_d;
      shadow_q  <= shadow_d;
      ext_irq_q <= ext_irq;
      rdata_q   <= rdata_d;
      rvalid_q  <= rd_hit;
      irq_q     <= irq_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_bus_irq_timer.sv
// Directed, table-driven bench for bus_irq_timer; each row is one bus cycle checked just after its edge.
module tb_bus_irq_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  ext_irq;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  bus_irq_timer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .AB      (AB),
    .DO      (DO),
    .WE      (WE),
    .ext_irq (ext_irq),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       hit;
    logic [2:0] off;
    logic [7:0] wd;
    logic [7:0] ext;
    logic       rdchk;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %02h, expected %02h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic hit, input logic [2:0] off,
                       input logic [7:0] wd, input logic [7:0] x);
    AB      = (hit ? 16'hFE00 : 16'hFD00) | {13'd0, off};
    DO      = wd;
    WE      = we;
    ext_irq = x;
  endtask

  task automatic op(input logic we, input logic [2:0] off, input logic [7:0] wd);
    drive(we, 1'b1, off, wd, 8'h00);
    @(posedge clk); #1;
  endtask

  task automatic R(input logic [2:0] o, input logic [7:0] e, input logic i, input logic [7:0] x = 8'h00);
    vecs.push_back('{we:1'b0, hit:1'b1, off:o, wd:8'h00, ext:x, rdchk:1'b1, exp_rd:e, exp_irq:i});
  endtask

  task automatic W(input logic [2:0] o, input logic [7:0] d, input logic i, input logic [7:0] x = 8'h00);
    vecs.push_back('{we:1'b1, hit:1'b1, off:o, wd:d, ext:x, rdchk:1'b0, exp_rd:8'h00, exp_irq:i});
  endtask

  task automatic I(input logic i, input logic [7:0] x = 8'h00);
    vecs.push_back('{we:1'b0, hit:1'b0, off:3'd0, wd:8'h00, ext:x, rdchk:1'b0, exp_rd:8'h00, exp_irq:i});
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rvalid", 0, {7'd0, rvalid}, 8'h00);
    chk("reset_irq",    0, {7'd0, irq},    8'h00);
    chk("reset_rdata",  0, rdata,          8'h00);
    reset_n = 1'b1;

`ifndef BUS_IRQ_TIMER_PRESCALE_EN
    // Auto-reload timer, RLD=3, CTRL=EN|AUTO|TIE.
    R(3'd4, 8'h00, 0);  I(0);
    W(3'd2, 8'h03, 0);  W(3'd3, 8'h00, 0);  W(3'd4, 8'h07, 0);
    I(0); I(0); I(0); I(0);
    R(3'd5, 8'h01, 1);
    R(3'd0, 8'h02, 1);  R(3'd0, 8'h01, 1);  R(3'd0, 8'h00, 1);  R(3'd0, 8'h03, 1);
    R(3'd5, 8'h81, 1);
    W(3'd5, 8'h01, 1);
    W(3'd5, 8'h01, 0);  // W1C meets a CNT==0 tick: TF stays set
    R(3'd5, 8'h01, 1);
    W(3'd4, 8'h00, 1);  W(3'd5, 8'h01, 0);  I(0);  R(3'd5, 8'h00, 0);
    // One-shot, RLD=2, CTRL=EN|TIE.
    W(3'd2, 8'h02, 0);  W(3'd3, 8'h00, 0);  W(3'd4, 8'h05, 0);
    I(0); I(0); I(0);
    R(3'd4, 8'h04, 1);  R(3'd0, 8'h00, 1);  R(3'd5, 8'h81, 1);
    W(3'd5, 8'h01, 1);  I(0);  R(3'd5, 8'h00, 0);  R(3'd0, 8'h00, 0);
    W(3'd4, 8'h00, 0);
    // External interrupts.
    W(3'd6, 8'h10, 0);
    I(0, 8'h10);  I(1);
    R(3'd7, 8'h10, 1);  R(3'd6, 8'h10, 1);
    I(1, 8'h10);  W(3'd7, 8'h10, 1, 8'h10);  I(0, 8'h10);
    R(3'd7, 8'h00, 0, 8'h10);  R(3'd5, 8'h00, 0);
    I(0, 8'h01);  R(3'd7, 8'h01, 0);  W(3'd7, 8'h01, 0);  R(3'd7, 8'h00, 0);
    vecs.push_back('{we:1'b1, hit:1'b0, off:3'd6, wd:8'hFF, ext:8'h00, rdchk:1'b0, exp_rd:8'h00, exp_irq:1'b0});
    R(3'd6, 8'h10, 0);
    W(3'd7, 8'h02, 0, 8'h02);  R(3'd7, 8'h02, 0);  W(3'd7, 8'h02, 0);
    // Counter shadow.
    W(3'd2, 8'h34, 0);  W(3'd3, 8'h12, 0);  R(3'd3, 8'h12, 0);  R(3'd0, 8'h34, 0);
    W(3'd4, 8'h01, 0);  I(0); I(0);  W(3'd4, 8'h00, 0);
    R(3'd1, 8'h12, 0);  R(3'd0, 8'h31, 0);
    W(3'd2, 8'h00, 0);  W(3'd3, 8'h01, 0);  R(3'd0, 8'h00, 0);
    W(3'd4, 8'h01, 0);  W(3'd4, 8'h00, 0);
    R(3'd1, 8'h01, 0);  R(3'd0, 8'hFF, 0);  R(3'd1, 8'h00, 0);
    // CTRL[7:4] writes are ignored and read back as 0.
    W(3'd4, 8'hF8, 0);  R(3'd4, 8'h00, 0);  W(3'd4, 8'h00, 0);
    // RLD_HI write in a tick cycle wins over the decrement.
    W(3'd2, 8'h05, 0);  W(3'd3, 8'h00, 0);  W(3'd4, 8'h01, 0);  I(0);
    W(3'd3, 8'h00, 0);  W(3'd4, 8'h00, 0);  R(3'd0, 8'h04, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].hit, vecs[i].off, vecs[i].wd, vecs[i].ext);
      @(posedge clk); #1;
      chk("rvalid", i, {7'd0, rvalid}, {7'd0, vecs[i].hit & ~vecs[i].we});
      if (vecs[i].rdchk) chk("rdata", i, rdata, vecs[i].exp_rd);
      chk("irq", i, {7'd0, irq}, {7'd0, vecs[i].exp_irq});
      $display("step %0d we=%0b hit=%0b off=%0d wd=%02h ext=%02h -> rvalid=%0b rdata=%02h irq=%0b",
               i, vecs[i].we, vecs[i].hit, vecs[i].off, vecs[i].wd, vecs[i].ext, rvalid, rdata, irq);
    end
`else
    // PS=2: one tick per 8 enabled cycles; 17 enabled cycles take CNT from 0x10 to 0x0E.
    op(1'b1, 3'd6, 8'h10);
    op(1'b1, 3'd2, 8'h10);
    op(1'b1, 3'd3, 8'h00);
    op(1'b1, 3'd4, 8'h21);
    repeat (16) op(1'b0, 3'd0, 8'h00);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    op(1'b1, 3'd4, 8'h20);
    op(1'b0, 3'd4, 8'h00);
    chk("ps_ctrl", 0, rdata, 8'h20);
    op(1'b0, 3'd0, 8'h00);
    chk("ps_cnt", 0, rdata, 8'h0E);
    $display("prescale: CNT_LO=%02h after 17 enabled cycles at PS=2", rdata);
`endif

    // Reset asserted while a read response is on the bus.
    op(1'b0, 3'd6, 8'h00);
    chk("midrd_rvalid", 0, {7'd0, rvalid}, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_rvalid", 0, {7'd0, rvalid}, 8'h00);
    chk("rst_rdata",  0, rdata,          8'h00);
    chk("rst_irq",    0, {7'd0, irq},    8'h00);
    @(posedge clk); #1;
    chk("rst_hold_rvalid", 0, {7'd0, rvalid}, 8'h00);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    reset_n = 1'b1;
    op(1'b0, 3'd6, 8'h00);
    chk("rst_xmask", 0, rdata, 8'h00);
    chk("rst_rd_rvalid", 0, {7'd0, rvalid}, 8'h01);
    $display("reset: XMASK after reset=%02h rvalid=%0b", rdata, rvalid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
